// File: rtl/ctu_top_topo.sv
// rtl/ctu_top_topo.sv - count-up mm:ss BCD timer with a minute limit and optional free-run wrap
module ctu_top_topo #(
    parameter int unsigned CLK_DIV       = 50_000_000,
    parameter bit          FREE_RUN_WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cnt_en,
    input  logic       load,
    input  logic [7:0] min_limit,
    output logic [7:0] xmin,
    output logic [7:0] xsec,
    output logic       sec_tick,
    output logic       wrap,
    output logic       time_up
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    xmin_q, xmin_d;
    logic [7:0]    xsec_q, xsec_d;
    logic [7:0]    limit_q, limit_d;
    logic          sec_tick_q, sec_tick_d;
    logic          wrap_q, wrap_d;
    logic          time_up_q, time_up_d;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Two-digit BCD increment; callers handle the 59 and 99 rollovers themselves.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        xmin_d     = xmin_q;
        xsec_d     = xsec_q;
        limit_d    = limit_q;
        time_up_d  = time_up_q;
        sec_tick_d = 1'b0;
        wrap_d     = 1'b0;

        if (load) begin
            state_d   = IDLE;
            presc_d   = '0;
            xmin_d    = 8'h00;
            xsec_d    = 8'h00;
            time_up_d = 1'b0;
            limit_d   = {clamp_digit(min_limit[7:4]), clamp_digit(min_limit[3:0])};
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_en && (FREE_RUN_WRAP || (limit_q != 8'h00))) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (cnt_en) begin
                        if (presc_q == PRESC_MAX) begin
                            presc_d    = '0;
                            sec_tick_d = 1'b1;
                            if (xsec_q == 8'h59) begin
                                xsec_d = 8'h00;
                                if (xmin_q == 8'h99) begin
                                    xmin_d = 8'h00;
                                    wrap_d = 1'b1;
                                end else begin
                                    xmin_d = bcd_inc(xmin_q);
                                end
                            end else begin
                                xsec_d = bcd_inc(xsec_q);
                            end
                            // Compare against the value being written so DONE lands on the final tick.
                            if ((limit_q != 8'h00) && (xmin_d == limit_q) && (xsec_d == 8'h00)) begin
                                state_d   = DONE;
                                time_up_d = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            xmin_q     <= 8'h00;
            xsec_q     <= 8'h00;
            limit_q    <= 8'h00;
            sec_tick_q <= 1'b0;
            wrap_q     <= 1'b0;
            time_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            xmin_q     <= xmin_d;
            xsec_q     <= xsec_d;
            limit_q    <= limit_d;
            sec_tick_q <= sec_tick_d;
            wrap_q     <= wrap_d;
            time_up_q  <= time_up_d;
        end
    end

    assign xmin     = xmin_q;
    assign xsec     = xsec_q;
    assign sec_tick = sec_tick_q;
    assign wrap     = wrap_q;
    assign time_up  = time_up_q;

endmodule

// File: tb/tb_ctu_top_topo.sv
// tb/tb_ctu_top_topo.sv - directed vector bench for the count-up mm:ss timer
module tb_ctu_top_topo;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       cnt_en = 1'b0;
    logic [7:0] min_limit = 8'h00;

    logic [7:0] xmin, xsec, xmin0, xsec0;
    logic       sec_tick, wrap, time_up, sec_tick0, wrap0, time_up0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctu_top_topo #(.CLK_DIV(CLK_DIV), .FREE_RUN_WRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .load(load), .min_limit(min_limit),
        .xmin(xmin), .xsec(xsec), .sec_tick(sec_tick), .wrap(wrap), .time_up(time_up)
    );

    ctu_top_topo #(.CLK_DIV(CLK_DIV), .FREE_RUN_WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .load(load), .min_limit(min_limit),
        .xmin(xmin0), .xsec(xsec0), .sec_tick(sec_tick0), .wrap(wrap0), .time_up(time_up0)
    );

    typedef struct {
        logic        rst;
        logic        load;
        logic        en;
        logic [7:0]  lim;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got min=%h sec=%h tick=%b wrap=%b up=%b, want min=%h sec=%h tick=%b wrap=%b up=%b",
                     name, act[18:11], act[10:3], act[2], act[1], act[0],
                     exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic l, input logic e, input logic [7:0] lim,
                       input logic [7:0] emin, input logic [7:0] esec,
                       input logic et, input logic ew, input logic eu);
        vec_t v;
        v.rst = r;
        v.load = l;
        v.en = e;
        v.lim = lim;
        v.exp = {emin, esec, et, ew, eu};
        tbl.push_back(v);
    endtask

    // Elapsed time tracked as an integer second count; BCD derived by division.
    task automatic check_run(input string name, input int n, input int s0, input int p0, input int lim_s);
        int   secs;
        int   presc;
        bit   done;
        logic tk;
        logic wr;
        secs = s0;
        presc = p0;
        done = 1'b0;
        rst = 1'b0;
        load = 1'b0;
        cnt_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tk = 1'b0;
            wr = 1'b0;
            if (!done) begin
                if (presc == CLK_DIV - 1) begin
                    presc = 0;
                    secs++;
                    tk = 1'b1;
                    if (secs == 6000) begin
                        secs = 0;
                        wr = 1'b1;
                    end
                    if (lim_s > 0 && secs == lim_s) done = 1'b1;
                end else begin
                    presc++;
                end
            end
            step();
            chk(name, {xmin, xsec, sec_tick, wrap, time_up},
                {to_bcd(secs / 60), to_bcd(secs % 60), tk, wr, done});
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic [7:0] lim);
        rst = r;
        load = l;
        cnt_en = e;
        min_limit = lim;
    endtask

    initial begin
        // Reset, load limit 01, first ticks, then a 10-cycle pause after 2 prescaler counts.
        add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 0, 8'h01, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 8'h01, 1, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 8'h02, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].load, tbl[i].en, tbl[i].lim);
            step();
            chk($sformatf("vec%0d", i), {xmin, xsec, sec_tick, wrap, time_up}, tbl[i].exp);
        end

        // Run on to the 01:00 limit, then confirm the frozen DONE state.
        check_run("t1_limit", 58 * CLK_DIV + 8, 2, 0, 60);

        // rst together with load while DONE; FREE_RUN_WRAP=0 with limit 00 must stay idle.
        chk("t6_done", {xmin0, xsec0, sec_tick0, wrap0, time_up0}, {8'h01, 8'h00, 1'b0, 1'b0, 1'b1});
        drive(1, 1, 1, 8'h45);
        step();
        chk("t6_rst", {xmin0, xsec0, sec_tick0, wrap0, time_up0}, 19'h0);
        chk("t6_rst_fr", {xmin, xsec, sec_tick, wrap, time_up}, 19'h0);
        drive(0, 0, 1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t6_idle", {xmin0, xsec0, sec_tick0, wrap0, time_up0}, 19'h0);
        end

        // Free-run wrap with limit 00.
        drive(1, 0, 0, 8'h00);
        step();
        chk("t3_rst", {xmin, xsec, sec_tick, wrap, time_up}, 19'h0);
        drive(0, 0, 1, 8'h00);
        step();
        chk("t3_enter", {xmin, xsec, sec_tick, wrap, time_up}, 19'h0);
        check_run("t3_wrap", 6000 * CLK_DIV + 8, 0, 0, 0);
        chk("t3_idle0", {xmin0, xsec0, sec_tick0, wrap0, time_up0}, 19'h0);

        // Digit clamp: 0x1F latches as 0x19.
        drive(0, 1, 0, 8'h1F);
        step();
        chk("t4_load", {xmin, xsec, sec_tick, wrap, time_up}, 19'h0);
        drive(0, 0, 1, 8'h00);
        step();
        chk("t4_enter", {xmin, xsec, sec_tick, wrap, time_up}, 19'h0);
        check_run("t4_clamp", 1140 * CLK_DIV + 8, 0, 0, 1140);

        // Load colliding with a tick edge at 00:37 aborts the run.
        drive(0, 1, 0, 8'h05);
        step();
        drive(0, 0, 1, 8'h00);
        step();
        chk("t5_enter", {xmin, xsec, sec_tick, wrap, time_up}, 19'h0);
        check_run("t5_run", 37 * CLK_DIV + 3, 0, 0, 300);
        drive(0, 1, 1, 8'h05);
        step();
        chk("t5_load_tick", {xmin, xsec, sec_tick, wrap, time_up}, 19'h0);
        step();
        chk("t5_load_hold", {xmin, xsec, sec_tick, wrap, time_up}, 19'h0);
        drive(0, 0, 1, 8'h00);
        step();
        chk("t5_reenter", {xmin, xsec, sec_tick, wrap, time_up}, 19'h0);
        check_run("t5_rerun", CLK_DIV + 1, 0, 0, 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctu_top_topo.md
Name: ctu_top_topo

Overview:
Count-up (stopwatch-style) mm:ss timer; the opposite counting direction to the existing countdown timer top. A parameterised prescaler derives a seconds tick from clk. A BCD seconds stage carries into a BCD minutes stage. The block stops and flags time_up when elapsed time reaches a loaded minute limit. It feeds the same 7-segment display path as the countdown block, with the same BCD output format.

Parameters:
CLK_DIV, 50_000_000, clk cycles per one-second tick (>=2); benches use 4
FREE_RUN_WRAP, 1, 1 = limit 00 counts forever, wrapping 99:59->00:00; 0 = limit 00 never counts (stays IDLE)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cnt_en  in  1  count enable; 0 pauses counting (prescaler and counters hold)
load  in  1  synchronous clear-and-latch: zero time, latch min_limit
min_limit  in  8  BCD minute limit {tens,units}, sampled only when load=1
xmin  out  8  BCD elapsed minutes {tens,units}, 00..99
xsec  out  8  BCD elapsed seconds {tens,units}, 00..59
sec_tick  out  1  one-cycle pulse on each counted second (registered)
wrap  out  1  one-cycle pulse when 99:59 rolls to 00:00 (free-run only)
time_up  out  1  high from reaching limit:00 until load/rst

Behaviour:
- Priority per edge: rst > load > tick/count > hold.
- rst: xmin=00, xsec=00, sec_tick=0, wrap=0, time_up=0, prescaler=0, limit=00, state=IDLE.
- load (rst=0): same clears as rst, but limit <= min_limit. Each BCD digit >9 is clamped to 9 when latched (e.g. 0x3C -> 0x39). Next state is IDLE. load held high keeps the block in IDLE.
- States:
  - IDLE: counters at 00:00. Go to RUN on the first edge with cnt_en=1. Exception: FREE_RUN_WRAP=0 and limit=00 stays in IDLE.
  - RUN: prescaler counts 0..CLK_DIV-1 on each edge with cnt_en=1.
  - DONE: all counting frozen, time_up=1. Leave only via load/rst.
- Tick condition: state=RUN, cnt_en=1, prescaler=CLK_DIV-1.
  - Prescaler returns to 0 on the same edge.
  - The first tick occurs CLK_DIV enabled cycles after entering RUN.
- On the tick edge:
  - sec_tick <= 1.
  - xsec increments in BCD: units 9->0 carries to tens; 59->00 carries into xmin.
  - xmin increments in BCD: 99->00 wraps and sets wrap <= 1 for one cycle.
  - sec_tick and wrap are 0 on every other edge.
- Limit compare: if limit!=00 and the new value equals {limit,00}, on that same edge:
  - state <= DONE, time_up <= 1;
  - xmin=limit and xsec=00 are displayed and held;
  - sec_tick pulses on that final tick.
- Limit 00 with FREE_RUN_WRAP=1: never reaches DONE; wraps indefinitely.
- Pause: cnt_en=0 in RUN holds prescaler and counters exactly. Resume continues the partial second (no restart).
- load during RUN or DONE aborts immediately: the next cycle shows 00:00 and time_up=0.
- load and a tick condition on the same edge: load wins, no sec_tick.
- cnt_en in DONE has no effect.
- Outputs are registers; no combinational path from inputs to outputs.
- Illegal BCD never appears on xmin/xsec.

Test Plan:
1. CLK_DIV=4; rst; load with min_limit=0x01; cnt_en=1 -> sec_tick every 4 clks; xsec 00,01..09,10..59. Then xmin=01, xsec=00, and time_up=1 on the same edge as the 60th tick. Further clocks are frozen, with no more sec_tick.
2. Pause: in RUN, drop cnt_en after 2 prescaler counts for 10 cycles, then raise it -> next tick arrives 2 enabled cycles later; xsec unchanged during pause.
3. Free-run wrap: limit=00, FREE_RUN_WRAP=1, run to 99:59 -> next tick gives 00:00 with wrap=1 for one cycle and time_up=0.
4. Clamp and limit: load min_limit=0x1F -> limit 0x19. Run -> time_up exactly at xmin=0x19, xsec=0x00, i.e. after 1140 ticks.
5. load mid-run at 00:37 coinciding with a tick edge -> next cycle 00:00, sec_tick=0, state IDLE. Re-run reaches 00:01 after 4 clks.
6. rst asserted in DONE (time_up=1) with load=1 simultaneously -> all outputs 0, limit=00. Then cnt_en=1 with FREE_RUN_WRAP=0 -> stays 00:00, no sec_tick.
